// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, sitting on the core data port.
// Register map by word offset: 0 TXDATA, 1 STATUS, 2 DIV, 3 reserved.
module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [13:0] d_addr,
  input  logic [31:0] dw_data,
  input  logic [1:0]  dw_size,
  output logic [31:0] d_data,
  output logic        tx,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [1:0]    off;
  logic          req, fire, prev_req_q;
  logic          push, push_ok, pop, full, empty;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   div_q;
  logic          ovf_q;
  state_e        state_q, state_d;
  logic [15:0]   bcnt_q, bcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d, busy_q, busy_d, irq_q;
  logic [31:0]   status, regval, d_data_q;
  logic          unused_ok;

  assign unused_ok = ^{d_addr[13:4], dw_data[31:16]};

  // Only the first cycle of a held store acts, so a stalled store pushes once.
  assign req     = sel && (dw_size != 2'b00);
  assign fire    = req && !prev_req_q;
  assign off     = d_addr[3:2];
  assign push    = fire && (off == 2'd0);
  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign push_ok = push && (!full || pop);
  assign cnt_d   = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        sh_d    = mem_q[rptr_q];
        bcnt_d  = div_q - 16'd1;
        state_d = START;
      end
      START: if (bcnt_q == '0) begin
        state_d = DATA;
        bidx_d  = 3'd0;
        bcnt_d  = div_q - 16'd1;
      end else bcnt_d = bcnt_q - 16'd1;
      DATA: if (bcnt_q == '0) begin
        sh_d   = sh_q >> 1;
        bcnt_d = div_q - 16'd1;
        if (bidx_q == 3'd7) state_d = STOP;
        else bidx_d = bidx_q + 3'd1;
      end else bcnt_d = bcnt_q - 16'd1;
      STOP: if (bcnt_q == '0) begin
        // Chain straight into the next start bit when more data is waiting.
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = mem_q[rptr_q];
          bcnt_d  = div_q - 16'd1;
          state_d = START;
        end else state_d = IDLE;
      end else bcnt_d = bcnt_q - 16'd1;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = sh_d[0];
    busy_d = (state_d != IDLE) || (cnt_d != '0);
  end

  always_comb begin
    status = (32'(cnt_q) << 8) | {28'd0, ovf_q, empty, full, busy_q};
    regval = 32'd0;
    unique case (off)
      2'd1:    regval = status;
      2'd2:    regval = {16'd0, div_q};
      default: regval = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= dw_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev_req_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      div_q      <= 16'(CLKS_PER_BIT);
      ovf_q      <= 1'b0;
      state_q    <= IDLE;
      bcnt_q     <= '0;
      bidx_q     <= '0;
      sh_q       <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      irq_q      <= 1'b1;
      d_data_q   <= '0;
    end else begin
      prev_req_q <= req;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      cnt_q      <= cnt_d;
      if (fire && off == 2'd2)
        div_q <= (dw_data[15:0] == 16'd0) ? 16'd1 : dw_data[15:0];
      if (push && !push_ok)                         ovf_q <= 1'b1;
      else if (fire && off == 2'd1 && dw_data[3])   ovf_q <= 1'b0;
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      bidx_q     <= bidx_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      irq_q      <= !busy_d;
      d_data_q   <= sel ? (regval >> {d_addr[1:0], 3'b000}) : 32'd0;
    end
  end

  assign d_data = d_data_q;
  assign tx     = tx_q;
  assign irq    = irq_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: scenario tasks plus a serial-line decoder that turns the
// recorded tx waveform back into bytes and frame start times.
module tb_mmio_uart_tx;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, resetn = 1'b0, sel = 1'b0;
  logic [13:0] d_addr = '0;
  logic [31:0] dw_data = '0;
  logic [1:0]  dw_size = '0;
  logic [31:0] d_data;
  logic        tx, irq;

  int tests = 0, fails = 0;
  bit rec = 1'b0;
  bit txlog[$];
  logic [7:0] dec_bytes[$];
  int dec_starts[$];
  int dec_bad;

  mmio_uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .sel(sel), .d_addr(d_addr), .dw_data(dw_data),
    .dw_size(dw_size), .d_data(d_data), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (rec) txlog.push_back(tx);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [1:0] sz);
    @(negedge clk); sel = 1'b1; d_addr = {10'd0, addr}; dw_data = data; dw_size = sz;
    @(negedge clk); sel = 1'b0; dw_size = 2'b00;
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] data);
    @(negedge clk); sel = 1'b1; d_addr = {10'd0, addr}; dw_size = 2'b00;
    @(negedge clk); data = d_data; sel = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while (!irq && n < bound) begin @(negedge clk); n++; end
    tests++;
    if (!irq) begin fails++; $display("FAIL %s: irq still low after %0d cycles", name, bound); end
  endtask

  // Decode 8N1 frames from txlog at a fixed divisor, sampling mid-bit.
  task automatic decode(input int div);
    int i;
    logic [7:0] b;
    dec_bytes.delete(); dec_starts.delete(); dec_bad = 0; i = 0;
    while (i < txlog.size()) begin
      if (txlog[i] == 1'b0) begin
        if (i + 10*div > txlog.size()) begin dec_bad++; break; end
        for (int k = 0; k < 8; k++) b[k] = txlog[i + (1+k)*div + div/2];
        if (txlog[i + div/2] != 1'b0 || txlog[i + 9*div + div/2] != 1'b1) dec_bad++;
        dec_bytes.push_back(b);
        dec_starts.push_back(i);
        i += 10*div;
      end else i++;
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_irq", 32'(irq), 32'd1);
    chk("reset_d_data", d_data, 32'd0);
    resetn = 1'b1;
    rd(4'h4, v); chk("reset_status", v, 32'h4);
    rd(4'h8, v); chk("reset_div", v, 32'd16);
  endtask

  task automatic test_single_byte;
    bit seq[10] = '{0,1,0,1,0,0,1,0,1,1};
    wr(4'h8, 32'd4, 2'b11);
    wr(4'h0, 32'hA5, 2'b01);
    chk("single_tx_before_start", 32'(tx), 32'd1);
    chk("single_irq_drop", 32'(irq), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) repeat (4) @(negedge clk);
      chk($sformatf("single_bit%0d", k), 32'(tx), 32'(seq[k]));
    end
    repeat (3) @(negedge clk);
    chk("single_irq_end_minus1", 32'(irq), 32'd0);
    @(negedge clk);
    chk("single_irq_rise", 32'(irq), 32'd1);
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    int cap, acc, fifo_cnt;
    bit ovf;
    // Idle shifter takes the first byte at once; the rest land well inside one frame.
    cap = DEPTH + 1;
    acc = (10 < cap) ? 10 : cap;
    ovf = (10 > cap);
    fifo_cnt = acc - 1;
    txlog.delete(); rec = 1'b1;
    for (int b = 1; b <= 10; b++) wr(4'h0, 32'(b), 2'b01);
    rd(4'h4, v);
    chk("b2b_status", v, 32'(1 | ((fifo_cnt == DEPTH) ? 2 : 0) | (ovf ? 8 : 0) | (fifo_cnt << 8)));
    wr(4'h4, 32'h8, 2'b11);
    rd(4'h4, v);
    chk("b2b_ovf_clear", 32'(v[3]), 32'd0);
    wait_idle(2000, "b2b_wait");
    repeat (4) @(negedge clk);
    rec = 1'b0;
    decode(4);
    chk("b2b_frames", 32'(dec_bytes.size()), 32'(acc));
    chk("b2b_framing", 32'(dec_bad), 32'd0);
    for (int k = 0; k < dec_bytes.size() && k < acc; k++) begin
      chk($sformatf("b2b_byte%0d", k), 32'(dec_bytes[k]), 32'(k + 1));
      chk($sformatf("b2b_gap%0d", k), 32'(dec_starts[k] - dec_starts[0]), 32'(40 * k));
    end
  endtask

  task automatic test_held_store;
    logic [31:0] v;
    txlog.delete(); rec = 1'b1;
    wr(4'h0, 32'h3C, 2'b11);
    @(negedge clk); sel = 1'b1; d_addr = 14'h0; dw_data = 32'h55; dw_size = 2'b11;
    repeat (3) @(negedge clk);
    sel = 1'b0; dw_size = 2'b00;
    rd(4'h4, v);
    chk("held_count", 32'(v[12:8]), 32'd1);
    wait_idle(1000, "held_wait");
    repeat (4) @(negedge clk);
    rec = 1'b0;
    decode(4);
    chk("held_frames", 32'(dec_bytes.size()), 32'd2);
    if (dec_bytes.size() == 2) begin
      chk("held_byte0", 32'(dec_bytes[0]), 32'h3C);
      chk("held_byte1", 32'(dec_bytes[1]), 32'h55);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] v;
    int zeros = 0;
    wr(4'h0, 32'h00, 2'b01);
    wr(4'h0, 32'h00, 2'b01);
    repeat (16) @(negedge clk);
    chk("mid_data_bit3", 32'(tx), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_reset_tx", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    rd(4'h4, v); chk("mid_status", v, 32'h4);
    txlog.delete(); rec = 1'b1;
    repeat (100) @(negedge clk);
    rec = 1'b0;
    foreach (txlog[i]) if (txlog[i] == 1'b0) zeros++;
    chk("mid_no_frames", 32'(zeros), 32'd0);
    chk("mid_irq", 32'(irq), 32'd1);
  endtask

  task automatic test_misaligned;
    logic [31:0] v;
    wr(4'h8, 32'h1234, 2'b10);
    rd(4'h9, v); chk("mis_div_b1", v, 32'h12);
    rd(4'h8, v); chk("mis_div", v, 32'h1234);
    rd(4'hA, v); chk("mis_div_b2", v, 32'h0);
    rd(4'h0, v); chk("mis_txdata", v, 32'h0);
    wr(4'hC, 32'hFFFF_FFFF, 2'b11);
    rd(4'hC, v); chk("mis_reserved", v, 32'h0);
    wr(4'h8, 32'h77, 2'b00);
    rd(4'h8, v); chk("mis_size0_ignored", v, 32'h1234);
    wr(4'h8, 32'h0, 2'b11);
    rd(4'h8, v); chk("mis_div_zero", v, 32'h1);
  endtask

  task automatic test_random;
    logic [7:0] exp[$];
    logic [31:0] data;
    int div, n;
    for (int it = 0; it < 4; it++) begin
      div = $urandom_range(1, 6);
      n   = $urandom_range(1, DEPTH);
      wr(4'h8, 32'(div), 2'b11);
      exp.delete(); txlog.delete(); rec = 1'b1;
      for (int j = 0; j < n; j++) begin
        data = $urandom();
        exp.push_back(data[7:0]);
        wr({2'b00, 2'($urandom_range(0, 3))}, data, 2'($urandom_range(1, 3)));
      end
      wait_idle(n * 10 * div + 100, "rand_wait");
      repeat (3) @(negedge clk);
      rec = 1'b0;
      decode(div);
      chk($sformatf("rand%0d_frames", it), 32'(dec_bytes.size()), 32'(exp.size()));
      chk($sformatf("rand%0d_framing", it), 32'(dec_bad), 32'd0);
      for (int k = 0; k < exp.size() && k < dec_bytes.size(); k++)
        chk($sformatf("rand%0d_byte%0d", it, k), 32'(dec_bytes[k]), 32'(exp[k]));
    end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_held_store;
    test_reset_mid_frame;
    test_misaligned;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits on the twitchcore data port beside the 16 KB RAM. It is the responder for the core's store/load protocol: `d_addr`, `dw_data`, `dw_size` in, registered `d_data` out. Bytes stored to TXDATA are queued in a FIFO and serialized 8N1 on `tx`. The parent address decoder asserts `sel` when `d_addr` falls in this block's window.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: reset value of DIV, in clocks per bit.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of 2 and no more than 16.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `sel` in 1: the current `d_addr` targets this block.
- `d_addr` in 14: byte address; only bits [3:2] are decoded.
- `dw_data` in 32: store data.
- `dw_size` in 2: `00` none, `01` byte, `10` half, `11` word.
- `d_data` out 32: registered read data.
- `tx` out 1: serial line, idle high.
- `irq` out 1: high when the FIFO is empty and the shifter is idle.

## Operation
Register map (word offset = `d_addr[3:2]`):
- 0 TXDATA
  - Write pushes `dw_data[7:0]`; the store width is irrelevant.
  - Reads return 0.
- 1 STATUS, read-only except bit 3:
  - bit0 busy = shifter active OR FIFO non-empty.
  - bit1 full.
  - bit2 empty.
  - bit3 overflow, sticky; writing 1 to bit 3 clears it.
  - bits[12:8] FIFO count.
  - All other bits 0.
- 2 DIV
  - bits[15:0] hold the divisor; a written value of 0 is stored as 1.
  - Reads return the stored value zero-extended.
- 3 reserved: reads 0, writes ignored.

Write request:
- A write request is `sel && dw_size != 0`.
- The action fires only on the first cycle of a contiguous request run, tracked by a registered `prev_req`.
- A single store held for several cycles therefore pushes exactly once.

Reads:
- Every cycle, `d_data <= sel ? (regval >> (8*d_addr[1:0])) : 32'b0`.
- Reads have no side effects.

FIFO:
- Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits, wrapping modulo depth.
- Count is held separately in log2(FIFO_DEPTH)+1 bits.
- A push while full is dropped and sets overflow.
- If push and pop land in the same cycle while full, the push is accepted and count is unchanged.
- Pop occurs only when the shifter loads.

Shifter FSM, states IDLE, START, DATA, STOP:
- IDLE: `tx=1`. If the FIFO is non-empty, pop into a shift register and go to START.
- START: `tx=0` for DIV clocks, then DATA with bit index 0.
- DATA: `tx=shreg[0]` for DIV clocks, then shift right. After bit index 7 go to STOP.
- STOP: `tx=1` for DIV clocks.
  - If the FIFO is non-empty at the last stop clock, pop and go directly to START, so frames are back-to-back with no idle gap.
  - Otherwise go to IDLE.
- A 16-bit bit counter counts from DIV-1 down to 0.
- DIV is sampled at each bit start, so a mid-frame DIV write takes effect at the next bit boundary.

## Timing
- Reset values: `tx=1`, `irq=1`, `d_data=0`, FIFO empty, overflow=0, DIV=`CLKS_PER_BIT`, state IDLE, `prev_req=0`.
- Reset mid-frame: `tx` is 1 at the first edge with `resetn` low. Queued bytes are discarded and no partial frame resumes.
- Read latency: 1 clock; `d_data` is valid the cycle after `d_addr`/`sel` are presented.
- Write effect: registers update at the edge that samples the request.
- STATUS reflects a push one cycle after the request edge.
- Latency from an idle TXDATA write to start of frame:
  - Request sampled at edge N.
  - FIFO non-empty after edge N; shifter pops at edge N+1.
  - `tx` falls after edge N+1, i.e. 2 clocks after the request.
- Frame length: exactly 10×DIV clocks. The start bit begins on the clock `tx` falls.
- `irq` and busy are registered from state/count. `irq` drops the cycle after a push into an idle block.

## Test plan
- **Reset state:** hold `resetn=0` for 3 clocks, then release. Read STATUS → `0x00000004`; `tx=1`, `irq=1`; read DIV → 16.
- **Single byte:** write DIV=4, then store byte 0xA5 to TXDATA.
  - `tx` falls 2 clocks after the request.
  - Sampling every 4 clocks gives 0,1,0,1,0,0,1,0,1,1 (LSB first).
  - `irq` rises after 40 clocks.
- **Back-to-back and full:** with DIV=4, write 0x01..0x09 (9 bytes, depth 8) rapidly.
  - The ninth is accepted only if the first pop coincides; otherwise STATUS bit3=1.
  - Frames appear with no idle gap.
  - Writing STATUS=0x8 clears the overflow flag.
- **Held store:** hold `sel=1`, `dw_size=11` with data 0x55 for 3 cycles → count=1, exactly one frame sent.
- **Reset mid-frame:** assert `resetn=0` during DATA bit 3 → `tx=1` at the next edge, count=0, and no further frames after release.
- **Misaligned read:** with DIV=0x1234, read `d_addr=offset 8+1` → `d_data=0x00000012`. Writing DIV=0 reads back 1.
